// File: rtl/credit_07_step1_if.sv
// Handshake bundles for credit_07_step1: a valid/ready stream and a
// latency-2 memory read port.

interface axis_if #(
   parameter int W = 8
) ();
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tlast;
   logic         tready;

   modport master (output tdata, output tvalid, output tlast, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

interface ram_rd_if ();
   logic        read;
   logic [7:0]  addr;
   logic [15:0] data;
   logic        data_we;

   modport master (output read, output addr, input  data, input  data_we);
   modport slave  (input  read, input  addr, output data, output data_we);
endinterface

// File: rtl/credit_07_step1.sv
// credit_07_step1: credit-flow-controlled dependent lookup, addr -> ram0 -> ram1 -> result.
// Define CREDIT_07_STEP1_ASSERT_EN to compile in simulation-only overflow/credit checks.

module cr_ram256x16 (
   input  logic        clk,
   input  logic        reset_p,
   input  logic        write,
   input  logic [7:0]  addr,
   input  logic [15:0] data,
   ram_rd_if.slave     rd
);
   logic [15:0] mem [256];
   logic [15:0] rd_d1;
   logic [15:0] rd_q;
   logic [1:0]  vld_q;

   // NOTE: the storage array has no reset; only the read-valid pipeline is cleared.
   always_ff @(posedge clk) begin
      if (write) mem[addr] <= data;
   end

   // Read samples mem before this cycle's write lands, so same-address R/W returns old data.
   always_ff @(posedge clk) begin
      if (rd.read) rd_d1 <= mem[rd.addr];
      rd_q <= rd_d1;
   end

   always_ff @(posedge clk) begin
      if (reset_p) vld_q <= '0;
      else         vld_q <= {vld_q[0], rd.read};
   end

   assign rd.data    = rd_q;
   assign rd.data_we = vld_q[1];
endmodule

module cr_fifo4 #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_p,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);
   logic [W-1:0] mem [4];
   logic [1:0]   wr_ptr;
   logic [1:0]   rd_ptr;
   logic [2:0]   count;
   logic         do_wr;
   logic         do_rd;

   assign do_wr = push & ~full;
   assign do_rd = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 2'd1;
         if (do_rd) rd_ptr <= rd_ptr + 2'd1;
         count <= count + 3'(do_wr) - 3'(do_rd);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == 3'd0);
   assign full  = (count == 3'd4);
endmodule

module credit_07_step1 (
   input  logic     clk,
   input  logic     reset_p,
   axis_if.slave    stream_addr,
   ram_rd_if.master ram0_rd,
   ram_rd_if.master ram1_rd,
   axis_if.master   stream_data
);
   logic [2:0]  credit0;
   logic [2:0]  credit1;
   logic [1:0]  ign_cnt;
   logic        rd_ok;
   logic        accept;
   logic        issue1;
   logic        w4_push;
   logic        w4_empty;
   logic        w4_full;
   logic [15:0] w4_head;
   logic        out_push;
   logic        out_pop;
   logic        out_empty;
   logic        out_full;
   logic [15:0] out_head;
   logic        fifo_w4_overflow;
   logic        fifo_out_overfow;

   // Returns of reads issued before a reset land in the first two cycles after release.
   assign rd_ok = (ign_cnt == 2'd0);

   assign stream_addr.tready = ~reset_p & (credit0 != 3'd0);
   assign accept             = stream_addr.tvalid & stream_addr.tready;
   assign ram0_rd.read       = accept;
   assign ram0_rd.addr       = stream_addr.tdata;
   assign w4_push            = ram0_rd.data_we & rd_ok;

   assign issue1       = ~reset_p & ~w4_empty & (credit1 != 3'd0);
   assign ram1_rd.read = issue1;
   assign ram1_rd.addr = w4_head[7:0];
   assign out_push     = ram1_rd.data_we & rd_ok;

   assign stream_data.tvalid = ~reset_p & ~out_empty;
   assign stream_data.tdata  = out_head;
   assign stream_data.tlast  = 1'b0;
   assign out_pop            = stream_data.tvalid & stream_data.tready;

   cr_fifo4 #(.W(16)) u_fifo_w4 (
      .clk     (clk),
      .reset_p (reset_p),
      .push    (w4_push),
      .din     (ram0_rd.data),
      .pop     (issue1),
      .head    (w4_head),
      .empty   (w4_empty),
      .full    (w4_full)
   );

   cr_fifo4 #(.W(16)) u_fifo_out (
      .clk     (clk),
      .reset_p (reset_p),
      .push    (out_push),
      .din     (ram1_rd.data),
      .pop     (out_pop),
      .head    (out_head),
      .empty   (out_empty),
      .full    (out_full)
   );

   // Each credit covers one slot of the downstream FIFO plus its read in flight.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         credit0          <= 3'd4;
         credit1          <= 3'd4;
         ign_cnt          <= 2'd2;
         fifo_w4_overflow <= 1'b0;
         fifo_out_overfow <= 1'b0;
      end else begin
         credit0 <= credit0 - 3'(accept) + 3'(issue1);
         credit1 <= credit1 - 3'(issue1) + 3'(out_pop);
         if (ign_cnt != 2'd0)      ign_cnt          <= ign_cnt - 2'd1;
         if (w4_push & w4_full)    fifo_w4_overflow <= 1'b1;
         if (out_push & out_full)  fifo_out_overfow <= 1'b1;
      end
   end

`ifdef CREDIT_07_STEP1_ASSERT_EN
   logic [1:0] r0_pend;
   logic [1:0] r1_pend;

   always_ff @(posedge clk) begin
      if (reset_p) begin
         r0_pend <= '0;
         r1_pend <= '0;
      end else begin
         r0_pend <= {r0_pend[0], accept};
         r1_pend <= {r1_pend[0], issue1};
         assert (!(w4_push && w4_full))   else $error("fifo_w4 overflow");
         assert (!(out_push && out_full)) else $error("fifo_out overflow");
         assert (credit0 <= 3'd4 && credit1 <= 3'd4) else $error("credit above 4");
         assert (!(accept && credit0 == 3'd0) && !(issue1 && credit1 == 3'd0))
            else $error("credit below 0");
         assert (!(w4_push && !r0_pend[1]))  else $error("ram0 data_we without read");
         assert (!(out_push && !r1_pend[1])) else $error("ram1 data_we without read");
      end
   end
`endif
endmodule

// File: tb/tb_credit_07_step1.sv
// Self-checking bench for credit_07_step1 with two cr_ram256x16 memories and a
// queue scoreboard: expected results queued at address accept, compared at output.

module tb_credit_07_step1;
   logic        clk = 1'b0;
   logic        reset_p;
   logic        ram_rst;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_d0;
   logic [15:0] wr_d1;

   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   int          n_acc    = 0;
   int          n_out    = 0;
   int          out_mark = 0;
   int          first_out_cyc = 0;
   int          last_out_cyc  = 0;
   int          last_acc_cyc  = 0;
   logic [15:0] exp_q [$];

   axis_if #(.W(8))  s_addr ();
   axis_if #(.W(16)) s_data ();
   ram_rd_if         r0 ();
   ram_rd_if         r1 ();

   credit_07_step1 dut (
      .clk         (clk),
      .reset_p     (reset_p),
      .stream_addr (s_addr),
      .ram0_rd     (r0),
      .ram1_rd     (r1),
      .stream_data (s_data)
   );

   cr_ram256x16 u_ram0 (
      .clk (clk), .reset_p (ram_rst), .write (wr_en), .addr (wr_addr), .data (wr_d0), .rd (r0)
   );

   cr_ram256x16 u_ram1 (
      .clk (clk), .reset_p (ram_rst), .write (wr_en), .addr (wr_addr), .data (wr_d1), .rd (r1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [15:0] model(logic [7:0] a);
      logic [15:0] w0;
      w0 = 16'h0100 | {8'h00, 8'hFF - a};
      return 16'hB000 | {8'h00, w0[7:0]};
   endfunction

   task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one address; queue its expected result when the handshake completes.
   task automatic send(logic [7:0] a);
      bit done = 0;
      s_addr.tdata  = a;
      s_addr.tvalid = 1'b1;
      for (int w = 0; w < 200 && !done; w++) begin
         @(negedge clk);
         if (s_addr.tready) begin
            exp_q.push_back(model(a));
            n_acc++;
            last_acc_cyc = cyc;
            done = 1;
         end
      end
      if (!done) check("accept_timeout", s_addr.tready, 1);
      @(posedge clk);
      #1;
      s_addr.tvalid = 1'b0;
   endtask

   task automatic wait_drain(string tag);
      int w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      check(tag, exp_q.size(), 0);
      tick();
   endtask

   always @(negedge clk) begin
      if (!reset_p && s_data.tvalid && s_data.tready) begin
         if (n_out == out_mark) first_out_cyc = cyc;
         last_out_cyc = cyc;
         n_out++;
         if (exp_q.size() == 0) check("spurious_output", exp_q.size(), 1);
         else                   check("result", s_data.tdata, exp_q.pop_front());
      end
   end

   initial begin
      int  base;
      bit  prod_done;
      reset_p       = 1'b1;
      ram_rst       = 1'b1;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_d0         = '0;
      wr_d1         = '0;
      s_addr.tdata  = '0;
      s_addr.tvalid = 1'b0;
      s_addr.tlast  = 1'b0;
      s_data.tready = 1'b1;

      // Reset held 300 cycles; memories are loaded meanwhile.
      for (int i = 0; i < 300; i++) begin
         if (i < 256) begin
            wr_en   = 1'b1;
            wr_addr = 8'(i);
            wr_d0   = 16'h0100 | {8'h00, 8'hFF - 8'(i)};
            wr_d1   = 16'hB000 | {8'h00, 8'(i)};
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         check("reset_idle", {s_addr.tready, s_data.tvalid, r0.read, r1.read}, 4'b0000);
         tick();
      end
      reset_p = 1'b0;
      ram_rst = 1'b0;
      check("flags_after_reset", {dut.fifo_w4_overflow, dut.fifo_out_overfow}, 2'b00);

      // Single beat: latency and exactly one output.
      base = n_out;
      send(8'h05);
      begin
         int w = 0;
         while (!s_data.tvalid && w < 20) begin
            @(negedge clk);
            w++;
         end
      end
      check("latency", cyc - last_acc_cyc, 6);
      check("single_value", s_data.tdata, 16'hB0FA);
      repeat (20) tick();
      check("single_count", n_out - base, 1);

      // 256 back-to-back addresses, consumer always ready.
      base     = n_out;
      out_mark = n_out;
      for (int i = 0; i < 256; i++) send(8'(i));
      wait_drain("sweep_drain");
      check("sweep_count", n_out - base, 256);
      check("sweep_throughput", last_out_cyc - first_out_cyc, 255);
      check("sweep_flags", {dut.fifo_w4_overflow, dut.fifo_out_overfow}, 2'b00);

      // Backpressure: consumer stalled while 20 addresses are offered.
      base = n_acc;
      s_data.tready = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) send(8'h20 + 8'(i));
         end
         begin
            repeat (40) tick();
            check("bp_accepted", n_acc - base, 8);
            check("bp_tready_low", s_addr.tready, 0);
            s_data.tready = 1'b1;
         end
      join
      wait_drain("bp_drain");
      check("bp_total", n_acc - base, 20);
      check("bp_flags", {dut.fifo_w4_overflow, dut.fifo_out_overfow}, 2'b00);

      // Random producer and consumer gaps over 500 addresses.
      base      = n_out;
      prod_done = 0;
      fork
         begin
            for (int i = 0; i < 500; i++) begin
               repeat ($urandom_range(0, 3)) tick();
               send(8'($urandom_range(0, 255)));
            end
            prod_done = 1;
         end
         begin
            int budget = 0;
            while ((!prod_done || exp_q.size() != 0) && budget < 20000) begin
               int gap = $urandom_range(0, 5);
               s_data.tready = 1'b0;
               repeat (gap) tick();
               s_data.tready = 1'b1;
               tick();
               budget += gap + 1;
            end
            check("rand_drain", exp_q.size(), 0);
         end
      join
      s_data.tready = 1'b1;
      check("rand_count", n_out - base, 500);
      check("rand_flags", {dut.fifo_w4_overflow, dut.fifo_out_overfow}, 2'b00);

      // One-cycle reset with three reads in flight.
      send(8'h40);
      send(8'h41);
      send(8'h42);
      reset_p = 1'b1;
      exp_q.delete();
      base = n_out;
      tick();
      reset_p = 1'b0;
      repeat (20) tick();
      check("no_stale_output", n_out - base, 0);
      check("credits_restored", {dut.credit0, dut.credit1}, {3'd4, 3'd4});
      send(8'h10);
      wait_drain("post_reset_drain");
      check("post_reset_count", n_out - base, 1);
      check("final_flags", {dut.fifo_w4_overflow, dut.fifo_out_overfow}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
